// File: rtl/muldiv_dispatch.sv
// muldiv_dispatch: RV32M execute front-end. MUL* ops go to the external multiplier; DIV/DIVU/REM/REMU
// run in a 1-bit-per-cycle restoring divider. Optional divide result cache: MULDIV_RESULT_CACHE_EN.
module muldiv_dispatch #(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd,
    output logic        ready,
    output logic [31:0] mul_factor1,
    output logic [31:0] mul_factor2,
    output logic [1:0]  mul_op,
    output logic        mul_valid,
    input  logic        mul_ready,
    input  logic [31:0] mul_product
);

    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("muldiv_dispatch: only XLEN=32 is supported");
        end
        if (DIV_UNROLL != 1) begin : g_bad_unroll
            $error("muldiv_dispatch: only DIV_UNROLL=1 is supported");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        MUL_WAIT = 4'b0010,
        DIV_CALC = 4'b0100,
        DIV_FIX  = 4'b1000
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [31:0] rd_reg;
    logic        ready_reg;
    logic        mul_valid_reg;
    logic [31:0] mul_factor1_reg, mul_factor2_reg;
    logic [1:0]  mul_op_reg;
    logic [31:0] rem_reg, quo_reg, div_reg;
    logic        neg_q_reg, neg_r_reg;

    logic        is_div, sgn_in, div_zero, div_ovf, cache_hit, quick;
    logic [31:0] quick_val, a_mag, b_mag, q_fix, r_fix;
    logic [32:0] step_shift;
    logic        step_ge;
    logic [31:0] step_diff;

`ifdef MULDIV_RESULT_CACHE_EN
    logic        cache_valid_reg;
    logic        cache_sgn_reg;
    logic [31:0] cache_a_reg, cache_b_reg, cache_quo_reg, cache_rem_reg;

    assign cache_hit = cache_valid_reg && (cache_sgn_reg == sgn_in)
                       && (cache_a_reg == rs1) && (cache_b_reg == rs2);
`else
    assign cache_hit = 1'b0;
`endif

    // Request decode; funct3[0]=0 selects the signed divide variants.
    assign is_div   = funct3[2];
    assign sgn_in   = ~funct3[0];
    assign div_zero = (rs2 == 32'h0);
    assign div_ovf  = sgn_in && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign quick    = div_zero || div_ovf || cache_hit;

    assign a_mag = (sgn_in && rs1[31]) ? (32'h0 - rs1) : rs1;
    assign b_mag = (sgn_in && rs2[31]) ? (32'h0 - rs2) : rs2;

    always_comb begin
        quick_val = 32'hFFFF_FFFF;
        if (div_zero) begin
            quick_val = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            quick_val = funct3[1] ? 32'h0 : 32'h8000_0000;
        end
`ifdef MULDIV_RESULT_CACHE_EN
        else if (cache_hit) begin
            quick_val = funct3[1] ? cache_rem_reg : cache_quo_reg;
        end
`endif
    end

    // One restoring step: the remainder takes the next dividend bit from the top of quo_reg.
    assign step_shift = {rem_reg, quo_reg[31]};
    assign step_ge    = (step_shift >= {1'b0, div_reg});
    assign step_diff  = step_shift[31:0] - div_reg;

    assign q_fix = neg_q_reg ? (32'h0 - quo_reg) : quo_reg;
    assign r_fix = neg_r_reg ? (32'h0 - rem_reg) : rem_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (ce) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (valid && !ready_reg) begin
                    if (!is_div) begin
                        state_next = MUL_WAIT;
                    end else if (!quick) begin
                        state_next = DIV_CALC;
                    end
                end
            end
            MUL_WAIT: begin
                if (mul_ready) begin
                    state_next = IDLE;
                end
            end
            DIV_CALC: begin
                if (cnt_reg == 5'd0) begin
                    state_next = DIV_FIX;
                end
            end
            DIV_FIX:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg         <= 5'd0;
            rd_reg          <= 32'h0;
            ready_reg       <= 1'b0;
            mul_valid_reg   <= 1'b0;
            mul_factor1_reg <= 32'h0;
            mul_factor2_reg <= 32'h0;
            mul_op_reg      <= 2'b00;
            rem_reg         <= 32'h0;
            quo_reg         <= 32'h0;
            div_reg         <= 32'h0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
            cache_valid_reg <= 1'b0;
            cache_sgn_reg   <= 1'b0;
            cache_a_reg     <= 32'h0;
            cache_b_reg     <= 32'h0;
            cache_quo_reg   <= 32'h0;
            cache_rem_reg   <= 32'h0;
`endif
        end else if (ce) begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid && !ready_reg) begin
                        // Operands are latched for both paths; the divide path reuses them
                        // as its record of signedness/op and original operands.
                        mul_factor1_reg <= rs1;
                        mul_factor2_reg <= rs2;
                        mul_op_reg      <= funct3[1:0];
                        if (!is_div) begin
                            mul_valid_reg <= 1'b1;
`ifdef MULDIV_RESULT_CACHE_EN
                            cache_valid_reg <= 1'b0;
`endif
                        end else if (quick) begin
                            rd_reg    <= quick_val;
                            ready_reg <= 1'b1;
                        end else begin
                            cnt_reg   <= 5'd31;
                            rem_reg   <= 32'h0;
                            quo_reg   <= a_mag;
                            div_reg   <= b_mag;
                            neg_q_reg <= sgn_in & (rs1[31] ^ rs2[31]);
                            neg_r_reg <= sgn_in & rs1[31];
                        end
                    end
                end
                MUL_WAIT: begin
                    if (mul_ready) begin
                        rd_reg        <= mul_product;
                        ready_reg     <= 1'b1;
                        mul_valid_reg <= 1'b0;
                    end
                end
                DIV_CALC: begin
                    rem_reg <= step_ge ? step_diff : step_shift[31:0];
                    quo_reg <= {quo_reg[30:0], step_ge};
                    cnt_reg <= cnt_reg - 5'd1;
                end
                DIV_FIX: begin
                    rd_reg    <= mul_op_reg[1] ? r_fix : q_fix;
                    ready_reg <= 1'b1;
`ifdef MULDIV_RESULT_CACHE_EN
                    cache_valid_reg <= 1'b1;
                    cache_sgn_reg   <= ~mul_op_reg[0];
                    cache_a_reg     <= mul_factor1_reg;
                    cache_b_reg     <= mul_factor2_reg;
                    cache_quo_reg   <= q_fix;
                    cache_rem_reg   <= r_fix;
`endif
                end
                default: begin
                    mul_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rd          = rd_reg;
    assign ready       = ready_reg;
    assign mul_factor1 = mul_factor1_reg;
    assign mul_factor2 = mul_factor2_reg;
    assign mul_op      = mul_op_reg;
    assign mul_valid   = mul_valid_reg;

endmodule

// File: tb/tb_muldiv_dispatch.sv
// Self-checking bench for muldiv_dispatch: directed and randomized ops against an arithmetic
// reference, a multiplier stub with random response delay, and a cache-aware latency model.
`timescale 1ns/1ps
module tb_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset, ce, valid;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, rd;
    logic        ready;
    logic [31:0] mul_factor1, mul_factor2;
    logic [1:0]  mul_op;
    logic        mul_valid;
    logic        mul_ready = 1'b0;
    logic [31:0] mul_product = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_dispatch dut (
        .clk(clk), .reset(reset), .ce(ce), .valid(valid), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ready(ready),
        .mul_factor1(mul_factor1), .mul_factor2(mul_factor2), .mul_op(mul_op),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_product(mul_product)
    );

`ifdef MULDIV_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    // RV32M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_calc(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Latency model: edges after the accept edge until ready is visible; -1 for the MUL path.
    bit          c_valid = 1'b0;
    bit          c_sgn;
    logic [31:0] c_a, c_b;

    function automatic int model_accept(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        bit sgn;
        sgn = ~f3[0];
        if (!f3[2]) begin
            c_valid = 1'b0;
            return -1;
        end
        if (b == 32'h0) return 0;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        if (CACHE_EN && c_valid && c_sgn == sgn && c_a == a && c_b == b) return 0;
        if (CACHE_EN) begin
            c_valid = 1'b1; c_sgn = sgn; c_a = a; c_b = b;
        end
        return 33;
    endfunction

    // Multiplier stub: random 1..5 cycle response, one-cycle mul_ready pulse.
    bit mdl_busy = 1'b0;
    int mdl_cnt  = 0;
    always @(posedge clk) begin
        bit rst_s, ce_s;
        rst_s = reset;
        ce_s  = ce;
        #1;
        if (rst_s) begin
            mul_ready = 1'b0;
            mdl_busy  = 1'b0;
        end else if (ce_s) begin
            if (mul_ready) begin
                mul_ready = 1'b0;
                mdl_busy  = 1'b0;
            end else if (mdl_busy) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mul_ready   = 1'b1;
                    mul_product = ref_calc({1'b0, mul_op}, mul_factor1, mul_factor2);
                end
            end else if (mul_valid) begin
                mdl_busy = 1'b1;
                mdl_cnt  = $urandom_range(1, 5);
            end
        end
    end

    // Issues one op, scrambles inputs after the accept edge, and returns what was observed.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len,
                          output logic [31:0] res, output int lat, output int exp_lat,
                          output bit single, output logic mv0, output logic mvd,
                          output logic [31:0] f1o, output logic [31:0] f2o, output logic [1:0] opo);
        int k;
        valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; ce = 1'b1;
        exp_lat = model_accept(f3, a, b);
        @(posedge clk); #1;
        mv0 = mul_valid; f1o = mul_factor1; f2o = mul_factor2; opo = mul_op;
        valid = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0;
        while (ready !== 1'b1 && lat < 200) begin
            k  = lat + 1;
            ce = (stall_at < 0) || (k < stall_at) || (k >= stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
        end
        ce = 1'b1;
        if (ready !== 1'b1) begin
            res = 'x; lat = -1; single = 1'b0; mvd = 1'bx;
            return;
        end
        res = rd;
        mvd = mul_valid;
        @(posedge clk); #1;
        single = (ready === 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] r, f1, f2; int lat, el; bit single; logic mv0, mvd; logic [1:0] op;
        run_op(3'b101, 32'd100, 32'd7, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        c_valid = 1'b0;
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h want %h", rd, 32'h0); end
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_vec++; if (mul_valid !== 1'b0) begin n_err++; $display("FAIL reset_mul_valid: got %b want 0", mul_valid); end
        n_vec++; if (mul_factor1 !== 32'h0 || mul_factor2 !== 32'h0) begin
            n_err++; $display("FAIL reset_factors: got %h/%h want 0/0", mul_factor1, mul_factor2); end
        n_vec++; if (mul_op !== 2'b00) begin n_err++; $display("FAIL reset_mul_op: got %b want 00", mul_op); end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  tf [3] = '{3'd0, 3'd3, 3'd2};
        logic [31:0] ta [3] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] te [3] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] r, f1, f2, a, b; int lat, el; bit single; logic mv0, mvd; logic [1:0] op; logic [2:0] f;
        for (int i = 0; i < 3; i++) begin
            run_op(tf[i], ta[i], tb[i], -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
            n_vec++; if (r !== te[i]) begin n_err++; $display("FAIL mul_dir_rd[%0d]: got %h want %h", i, r, te[i]); end
            n_vec++; if (mv0 !== 1'b1 || mvd !== 1'b0) begin
                n_err++; $display("FAIL mul_dir_valid[%0d]: after accept %b at done %b want 1/0", i, mv0, mvd); end
            n_vec++; if (f1 !== ta[i] || f2 !== tb[i] || op !== tf[i][1:0]) begin
                n_err++; $display("FAIL mul_dir_latch[%0d]: got %h %h %b want %h %h %b", i, f1, f2, op, ta[i], tb[i], tf[i][1:0]); end
            n_vec++; if (!single) begin n_err++; $display("FAIL mul_dir_pulse[%0d]: got multi-cycle want one", i); end
        end
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            run_op(f, a, b, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
            n_vec++; if (r !== ref_calc(f, a, b) || !single) begin
                n_err++; $display("FAIL mul_rand f3=%0d %h*%h: got %h want %h single=%0d", f, a, b, r, ref_calc(f, a, b), single); end
        end
    endtask

    task automatic test_div_directed();
        logic [2:0]  tf [7] = '{3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] ta [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb [7] = '{32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] r, f1, f2; int lat, el; bit single; logic mv0, mvd; logic [1:0] op;
        for (int i = 0; i < 7; i++) begin
            run_op(tf[i], ta[i], tb[i], -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
            n_vec++; if (r !== te[i] || lat !== el || !single) begin
                n_err++; $display("FAIL div_dir[%0d]: rd %h lat %0d single %0d want %h lat %0d single 1", i, r, lat, single, te[i], el); end
        end
    endtask

    function automatic logic [31:0] pick_operand(int cls);
        case (cls)
            0: return 32'($urandom_range(0, 15));
            1: return 32'h0;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_div_random();
        logic [31:0] r, f1, f2, a, b; int lat, el; bit single; logic mv0, mvd; logic [1:0] op; logic [2:0] f;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(4, 7));
            a = pick_operand($urandom_range(0, 9));
            b = pick_operand($urandom_range(0, 9));
            run_op(f, a, b, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
            n_vec++; if (r !== ref_calc(f, a, b) || lat !== el || !single) begin
                n_err++; $display("FAIL div_rand f3=%0d %h/%h: rd %h lat %0d want %h lat %0d", f, a, b, r, lat, ref_calc(f, a, b), el); end
        end
    endtask

    task automatic test_ce_stall();
        logic [31:0] r, f1, f2; int lat, el, want; bit single; logic mv0, mvd; logic [1:0] op;
        run_op(3'd4, 32'd1000, 32'd3, 5, 10, r, lat, el, single, mv0, mvd, f1, f2, op);
        want = (el == 33) ? 43 : el;
        n_vec++; if (r !== 32'd333 || lat !== want) begin
            n_err++; $display("FAIL ce_stall_div: rd %0d lat %0d want 333 lat %0d", r, lat, want); end
        // ce low while a request is presented: no accept, no pulse
        valid = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0; ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ce_hold_accept: ready %b want 0", ready); end
        ce = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; ce = 1'b0;
        n_vec++; if (ready !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL ce_accept: ready %b rd %h want 1 ffffffff", ready, rd); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL ce_stretch[%0d]: ready %b want 1", i, ready); end
        end
        ce = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ce_release: ready %b want 0", ready); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r, f1, f2; int lat, el, seen; bit single; logic mv0, mvd; logic [1:0] op;
        logic [2:0]  tf [2] = '{3'd4, 3'd0};
        int          tr [2] = '{5, 1};
        for (int t = 0; t < 2; t++) begin
            valid = 1'b1; funct3 = tf[t]; rs1 = 32'd1000; rs2 = 32'd3; ce = 1'b1;
            @(posedge clk); #1;
            valid = 1'b0;
            seen = 0;
            for (int k = 1; k <= 45; k++) begin
                reset = (k == tr[t]);
                @(posedge clk); #1;
                if (ready === 1'b1) seen++;
            end
            reset = 1'b0;
            c_valid = 1'b0;
            n_vec++; if (seen !== 0 || mul_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_mid_op[%0d]: ready pulses %0d mul_valid %b want 0 0", t, seen, mul_valid); end
        end
        run_op(3'd5, 32'd1000, 32'd3, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
        n_vec++; if (r !== 32'd333 || lat !== el) begin
            n_err++; $display("FAIL reset_recover: rd %0d lat %0d want 333 lat %0d", r, lat, el); end
    endtask

    task automatic test_cache();
        logic [31:0] r, f1, f2; int lat, el; bit single; logic mv0, mvd; logic [1:0] op;
        logic [2:0]  tf [5] = '{3'd0, 3'd4, 3'd6, 3'd0, 3'd6};
        logic [31:0] te [5] = '{32'd700, 32'd14, 32'd2, 32'd700, 32'd2};
        for (int i = 0; i < 5; i++) begin
            run_op(tf[i], 32'd100, 32'd7, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
            n_vec++; if (r !== te[i] || (el >= 0 && lat !== el)) begin
                n_err++; $display("FAIL cache[%0d]: rd %0d lat %0d want %0d lat %0d", i, r, lat, te[i], el); end
        end
        run_op(3'd5, 32'd100, 32'd7, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
        n_vec++; if (r !== 32'd14 || lat !== el) begin
            n_err++; $display("FAIL cache_sign: rd %0d lat %0d want 14 lat %0d", r, lat, el); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, f1, f2, a, b; int lat, el; bit single; logic mv0, mvd; logic [1:0] op; logic [2:0] f;
        logic        pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        // valid held through the ready cycle: the op re-issues only every other edge
        valid = 1'b1; funct3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0; ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++; if (ready !== pat[i]) begin n_err++; $display("FAIL b2b_held[%0d]: ready %b want %b", i, ready, pat[i]); end
        end
        valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_drop: ready %b want 0", ready); end
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7)); a = $urandom; b = pick_operand($urandom_range(0, 9));
            run_op(f, a, b, -1, 0, r, lat, el, single, mv0, mvd, f1, f2, op);
            n_vec++; if (r !== ref_calc(f, a, b) || (el >= 0 && lat !== el) || !single) begin
                n_err++; $display("FAIL b2b_mix f3=%0d %h,%h: rd %h lat %0d want %h lat %0d", f, a, b, r, lat, ref_calc(f, a, b), el); end
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; valid = 1'b0; funct3 = 3'd0; rs1 = 32'h0; rs2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_mul();
        test_div_directed();
        test_div_random();
        test_ce_stall();
        test_reset_mid_op();
        test_cache();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
